kv_cell_controller: RTL

- Sequences GET/PUT/DEL requests onto a flat array of NUM_CELLS key/value memory cells. Each cell exposes write_op, key_in, value_in, key_out, value_out and used_out; used means key_out != 0.
- The block performs associative lookup, selects a free cell, and drives exactly one cell write per operation.
- It sits between the host command interface and the cell array, and is the only writer of the cells.

---
 rtl/kv_cell_controller.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/kv_cell_controller.sv
// Key/value cell sequencer: associative lookup, free-cell pick, one cell write per request.
// Response 2 edges after accept (3 for PUT/DEL writes); one request in flight, stalls in RESP until resp_ready.
module kv_cell_controller #(
  parameter int NUM_CELLS   = 8,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_op,
  input  logic [KEY_WIDTH-1:0]               req_key,
  input  logic [VALUE_WIDTH-1:0]             req_value,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [1:0]                         resp_status,
  output logic [VALUE_WIDTH-1:0]             resp_value,
  output logic [NUM_CELLS-1:0]               cell_write_op,
  output logic [KEY_WIDTH-1:0]               cell_key_in,
  output logic [VALUE_WIDTH-1:0]             cell_value_in,
  input  logic [NUM_CELLS*KEY_WIDTH-1:0]     cell_key_out,
  input  logic [NUM_CELLS*VALUE_WIDTH-1:0]   cell_value_out,
  input  logic [NUM_CELLS-1:0]               cell_used,
  output logic [$clog2(NUM_CELLS+1)-1:0]     occupancy
);

  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam int OCC_W = $clog2(NUM_CELLS + 1);

  localparam logic [1:0] OP_GET  = 2'b01;
  localparam logic [1:0] OP_PUT  = 2'b10;
  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_MISS = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITE, S_RESP} state_t;

  typedef struct packed {
    logic [1:0]             op;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } req_t;

  state_t                 state_q, state_d;
  req_t                   req_q;
  logic [IDX_W-1:0]       wr_idx_q;
  logic [KEY_WIDTH-1:0]   wr_key_q;
  logic [VALUE_WIDTH-1:0] wr_value_q;
  logic [1:0]             status_q;
  logic [VALUE_WIDTH-1:0] rvalue_q;

  logic                   hit, free;
  logic [IDX_W-1:0]       hit_idx, free_idx;
  logic [VALUE_WIDTH-1:0] hit_value;
  logic [OCC_W-1:0]       occ_count;

  logic                   dec_write;
  logic [1:0]             dec_status;
  logic [VALUE_WIDTH-1:0] dec_rvalue;
  logic [IDX_W-1:0]       dec_idx;
  logic [KEY_WIDTH-1:0]   dec_key;
  logic [VALUE_WIDTH-1:0] dec_value;

  // Scan from the top down so the lowest matching / free index is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    hit_value = '0;
    free      = 1'b0;
    free_idx  = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (cell_used[i] && (cell_key_out[i*KEY_WIDTH +: KEY_WIDTH] == req_q.key)) begin
        hit       = 1'b1;
        hit_idx   = IDX_W'(i);
        hit_value = cell_value_out[i*VALUE_WIDTH +: VALUE_WIDTH];
      end
      if (!cell_used[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    occ_count = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      occ_count = occ_count + OCC_W'(cell_used[i]);
    end
  end

  always_comb begin
    dec_write  = 1'b0;
    dec_status = ST_OK;
    dec_rvalue = '0;
    dec_idx    = '0;
    dec_key    = '0;
    dec_value  = '0;
    if (req_q.op == 2'b00 || req_q.key == '0) begin
      dec_status = ST_ERR;
    end else if (req_q.op == OP_GET) begin
      if (hit) dec_rvalue = hit_value;
      else     dec_status = ST_MISS;
    end else if (req_q.op == OP_PUT) begin
      if (hit || free) begin
        dec_write = 1'b1;
        dec_idx   = hit ? hit_idx : free_idx;
        dec_key   = req_q.key;
        dec_value = req_q.value;
      end else begin
        dec_status = ST_FULL;
      end
    end else begin
      // DEL clears the cell by writing the reserved empty key with a zero value.
      if (hit) begin
        dec_write = 1'b1;
        dec_idx   = hit_idx;
      end else begin
        dec_status = ST_MISS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    cell_write_op = '0;
    cell_key_in   = '0;
    cell_value_in = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = dec_write ? S_WRITE : S_RESP;
      S_WRITE: begin
        // Gated by rst so an abandoned write never lands on the reset edge.
        if (!rst) begin
          cell_write_op = NUM_CELLS'(1) << wr_idx_q;
          cell_key_in   = wr_key_q;
          cell_value_in = wr_value_q;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = !rst;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_status = status_q;
  assign resp_value  = rvalue_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= '0;
      wr_idx_q   <= '0;
      wr_key_q   <= '0;
      wr_value_q <= '0;
      status_q   <= ST_OK;
      rvalue_q   <= '0;
      occupancy  <= '0;
    end else begin
      occupancy <= occ_count;
      if (state_q == S_IDLE && req_valid) begin
        req_q <= '{op: req_op, key: req_key, value: req_value};
      end
      if (state_q == S_LOOKUP) begin
        status_q   <= dec_status;
        rvalue_q   <= dec_rvalue;
        wr_idx_q   <= dec_idx;
        wr_key_q   <= dec_key;
        wr_value_q <= dec_value;
      end
      if (state_q == S_WRITE) status_q <= ST_OK;
      if (state_q == S_RESP && resp_ready) begin
        status_q <= ST_OK;
        rvalue_q <= '0;
      end
    end
  end

endmodule
